// File: rtl/core_csr_access.sv
// core_csr_access: CSR access sequencer between execute and the CSR file / timer.
// Handles one READ/WRITE/SET/CLEAR request at a time. The response (old value)
// comes 3 cycles after accept. 64-bit timer reads are split into two 32-bit halves.
// Optional feature: define CORE_CSR_TIME_SNAPSHOT_EN so that a timer-low read
// latches the high half. The next timer-high read then returns that latched
// value, which gives a consistent 64-bit read even if the low half carries.
// TIMER_W must equal 2*CSR_WIDTH.
//
// state | meaning
// IDLE  | ready for a request; csr_addr driven to 0
// READ  | csr_addr presented, old value captured
// WRITE | new value driven, csr_we when legal and modifying
// RESP  | one-cycle response pulse with old value / error
module core_csr_access #(
  parameter int CSR_WIDTH = 32,
  parameter int CSR_AW    = 5,
  parameter int TIMER_W   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [1:0]           req_op,
  input  logic [1:0]           req_tsel,
  input  logic [CSR_AW-1:0]    req_addr,
  input  logic [CSR_WIDTH-1:0] req_wdata,
  output logic                 resp_valid,
  output logic [CSR_WIDTH-1:0] resp_rdata,
  output logic                 resp_err,
  output logic [CSR_AW-1:0]    csr_addr,
  input  logic [CSR_WIDTH-1:0] csr_rd_data,
  output logic                 csr_we,
  output logic [CSR_WIDTH-1:0] csr_wdata,
  input  logic [TIMER_W-1:0]   time_in
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  localparam logic [1:0] TS_CSR = 2'b00;
  localparam logic [1:0] TS_LO  = 2'b01;
  localparam logic [1:0] TS_HI  = 2'b10;
  localparam logic [1:0] TS_ILL = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    READ  = 2'b01,
    WRITE = 2'b10,
    RESP  = 2'b11
  } state_t;

  state_t                 state_q, state_d;
  logic [1:0]             op_q, tsel_q;
  logic [CSR_AW-1:0]      addr_q;
  logic [CSR_WIDTH-1:0]   wdata_q;
  logic [CSR_WIDTH-1:0]   old_q;
  logic [CSR_WIDTH-1:0]   new_val;
  logic [CSR_WIDTH-1:0]   timer_hi;
  logic [CSR_AW-1:0]      csr_addr_q;
  logic                   accept;
  logic                   wdata_nz;
  logic                   modifies;
  logic                   err;
  logic                   we_ok;

  assign accept   = req_valid && req_ready;
  assign wdata_nz = |wdata_q;

  // SET/CLEAR with a zero operand is a pure read and is legal on the timer.
  assign modifies = (op_q == OP_WRITE) || (op_q[1] && wdata_nz);
  assign err      = (tsel_q == TS_ILL) || ((tsel_q != TS_CSR) && modifies);
  assign we_ok    = (tsel_q == TS_CSR) && modifies;
  assign csr_addr = csr_addr_q;

  // New value from the captured old value and operand.
  always_comb begin
    new_val = old_q;
    case (op_q)
      OP_WRITE: new_val = wdata_q;
      OP_SET:   new_val = old_q | wdata_q;
      OP_CLEAR: new_val = old_q & ~wdata_q;
      default:  new_val = old_q;
    endcase
  end

`ifdef CORE_CSR_TIME_SNAPSHOT_EN
  logic [CSR_WIDTH-1:0] snap_q;
  logic                 snap_valid_q;

  // A legal low read latches the high half. A legal high read consumes the snapshot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      snap_q       <= '0;
      snap_valid_q <= 1'b0;
    end else if (state_q == READ && !err) begin
      if (tsel_q == TS_LO) begin
        snap_q       <= time_in[TIMER_W-1:CSR_WIDTH];
        snap_valid_q <= 1'b1;
      end else if (tsel_q == TS_HI) begin
        snap_valid_q <= 1'b0;
      end
    end
  end

  assign timer_hi = snap_valid_q ? snap_q : time_in[TIMER_W-1:CSR_WIDTH];
`else
  assign timer_hi = time_in[TIMER_W-1:CSR_WIDTH];
`endif

  // Request capture on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q    <= OP_READ;
      tsel_q  <= TS_CSR;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      op_q    <= req_op;
      tsel_q  <= req_tsel;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Registered CSR address: valid across READ and WRITE, zero otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_addr_q <= '0;
    end else if (accept) begin
      csr_addr_q <= req_addr;
    end else if (state_q == WRITE) begin
      csr_addr_q <= '0;
    end
  end

  // Old-value capture in READ from the selected source.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      old_q <= '0;
    end else if (state_q == READ) begin
      case (tsel_q)
        TS_CSR:  old_q <= csr_rd_data;
        TS_LO:   old_q <= time_in[CSR_WIDTH-1:0];
        TS_HI:   old_q <= timer_hi;
        default: old_q <= '0;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and decoded outputs.
  always_comb begin
    state_d    = state_q;
    req_ready  = 1'b0;
    csr_we     = 1'b0;
    csr_wdata  = '0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = '0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_d = READ;
      end
      READ: begin
        state_d = WRITE;
      end
      WRITE: begin
        csr_we    = we_ok;
        csr_wdata = new_val;
        state_d   = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        resp_err   = err;
        resp_rdata = err ? '0 : old_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
